pe_bus_responder: RTL and testbench
===================================

Name: pe_bus_responder

Overview:
- Bus-side responder for one RISC-V processing element (PE) tile in the CGRA.
- Serves the PE's three request types on the tile bus:
  - operand register reads: reg_select with rs1Out/rs2Out
  - register writeback: rdWrite with rdOut/result_out
  - memory load/store: mem_read/mem_write with mem_address
- Returns operands on AmuxIn/BmuxIn with data_Ready, and acknowledges memory operations with mem_ack.
- Owns the tile's 32x32 architectural register file and bridges loads/stores to a req/gnt/rvalid memory port.

Parameters:
- MEM_TIMEOUT, 255: max cycles in MEM_REQ+MEM_WAIT before abort with bus_err (legal range 1-65535).
- ZERO_REG, 1: 1 = x0 reads 0 and ignores writes; 0 = x0 is an ordinary register.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- reg_select  in  1  PE operand read request (level, four-phase)
- rs1Out  in  5  source register 1 index
- rs2Out  in  5  source register 2 index
- rdOut  in  5  destination register index
- rdWrite  in  1  PE writeback request
- result_out  in  32  writeback data / store data
- mem_read  in  1  PE load request (level, four-phase)
- mem_write  in  1  PE store request (level, four-phase)
- mem_address  in  32  load/store byte address, passed through unmodified
- AmuxIn  out  32  rs1 operand, or load data
- BmuxIn  out  32  rs2 operand
- data_Ready  out  1  operand response valid
- mem_ack  out  1  memory operation complete
- m_req  out  1  memory-port request
- m_we  out  1  memory-port write enable
- m_addr  out  32  memory-port address
- m_wdata  out  32  memory-port write data
- m_gnt  in  1  memory-port request accepted
- m_rvalid  in  1  memory-port read data valid
- m_rdata  in  32  memory-port read data
- bus_err  out  1  sticky memory timeout flag

Behaviour:
- Reset (reset=0, async):
  - FSM -> IDLE; timeout counter cleared.
  - All outputs 0, including AmuxIn, BmuxIn, bus_err.
  - Register file cleared to 0.
  - Reset mid-transaction drops m_req immediately; no further handshake completes.
- FSM states: IDLE, REG_RSP, MEM_REQ, MEM_WAIT, DONE.
- IDLE request priority: mem_write > mem_read > reg_select. Lower-priority requests stay pending (levels).
- Writeback (rdWrite=1, mem_read=0):
  - Taken in any state, single cycle: regfile[rdOut] <= result_out.
  - Ignored when rdOut==0 and ZERO_REG=1.
  - No ack is generated.
- Operand read:
  - reg_select sampled high in IDLE at edge N -> REG_RSP.
  - At N+1: AmuxIn=regfile[rs1Out], BmuxIn=regfile[rs2Out], data_Ready=1, all registered.
  - Same-cycle writeback to a read index bypasses: the new value is returned.
  - x0 returns 0 when ZERO_REG=1.
- Store:
  - IDLE -> MEM_REQ: m_req=1, m_we=1, m_addr=mem_address, m_wdata=result_out.
  - These outputs stay stable until a cycle with m_gnt=1.
  - That cycle -> DONE with mem_ack=1.
- Load:
  - IDLE -> MEM_REQ: m_req=1, m_we=0.
  - On m_gnt -> MEM_WAIT with m_req=0.
  - On m_rvalid: AmuxIn <= m_rdata; if rdWrite=1, also regfile[rdOut] <= m_rdata (x0 rule applies).
  - -> DONE with mem_ack=1.
  - m_gnt and m_rvalid in the same cycle: data is taken directly in that cycle; MEM_WAIT is skipped.
- DONE (four-phase handshake):
  - data_Ready / mem_ack held high until reg_select, mem_read and mem_write are all 0.
  - Then both drop the next cycle, FSM -> IDLE.
  - Minimum turnaround is 1 idle cycle between transactions.
  - REG_RSP moves to DONE immediately and holds data_Ready.
- Timeout:
  - Counter increments every cycle in MEM_REQ/MEM_WAIT.
  - When it reaches MEM_TIMEOUT: m_req=0, bus_err=1 (sticky until reset).
  - AmuxIn=0, no register write, -> DONE with mem_ack=1 so the PE never hangs.
  - Counter clears on entry to IDLE.
- PE request withdrawn before completion: the transaction still completes on the memory side; DONE then exits on the next cycle.
- m_rvalid outside MEM_WAIT (or outside the same-cycle gnt case) is ignored. m_gnt outside MEM_REQ is ignored.

Test Plan:
- Writeback then read: after reset, rdWrite with rdOut=5, result_out=0x1234_5678; then reg_select with rs1Out=5, rs2Out=0 -> one edge later AmuxIn=0x12345678, BmuxIn=0, data_Ready=1; data_Ready stays high until reg_select drops, then goes low one cycle later.
- Bypass: rdWrite rdOut=7, result_out=0xA5A5A5A5 in the same cycle as reg_select rs1Out=7 -> AmuxIn=0xA5A5A5A5.
- Store:
  - Stimulus: mem_write, mem_address=0x100, result_out=0xCAFEF00D; m_gnt held low 3 cycles.
  - Required: m_req/m_we/m_addr/m_wdata stable for those 3 cycles; mem_ack rises the cycle after m_gnt.
- Load with writeback:
  - Stimulus: mem_read+rdWrite, rdOut=9, mem_address=0x200; m_gnt, then m_rvalid 2 cycles later with m_rdata=0x0000BEEF.
  - Required: mem_ack=1, AmuxIn=0xBEEF; a later read of rs1=9 returns 0xBEEF. Repeat with rdOut=0 -> x0 still reads 0.
- Priority and timeout:
  - mem_write+reg_select raised together -> store served first; data_Ready only after the store's four-phase completes.
  - MEM_TIMEOUT=4 with m_gnt tied low -> bus_err=1 and mem_ack=1 after 4 request cycles; bus_err stays high across later transactions.
- Reset mid-load: assert reset in MEM_WAIT -> m_req, mem_ack, AmuxIn and bus_err are 0 immediately; a late m_rvalid is ignored.

Source files
------------

// File: rtl/pe_bus_responder.sv
// Tile-bus responder for one PE: owns the 32x32 register file and bridges loads/stores to a req/gnt/rvalid port.
// Latency: operand read 2 edges after reg_select; memory ops finish on grant (store) or rvalid (load), or on timeout.
// Backpressure: four-phase PE handshake; DONE holds data_Ready/mem_ack until every PE request level is low.
module pe_bus_responder #(
    parameter int MEM_TIMEOUT = 255,
    parameter int ZERO_REG    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_select,
    input  logic [4:0]  rs1Out,
    input  logic [4:0]  rs2Out,
    input  logic [4:0]  rdOut,
    input  logic        rdWrite,
    input  logic [31:0] result_out,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    output logic [31:0] AmuxIn,
    output logic [31:0] BmuxIn,
    output logic        data_Ready,
    output logic        mem_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        bus_err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] REG_RSP  = 3'd1;
    localparam logic [2:0] MEM_REQ  = 3'd2;
    localparam logic [2:0] MEM_WAIT = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    logic [2:0]  state;
    logic [15:0] tmo_cnt;
    logic        is_store;
    logic [31:0] regfile [32];

    logic        rd_ok;
    logic        wb_en;
    logic        load_done;
    logic        tmo_hit;
    logic        rf_we;
    logic [31:0] rf_wd;
    logic [31:0] rd_a;
    logic [31:0] rd_b;

    always_comb begin
        rd_ok     = !((ZERO_REG != 0) && (rdOut == 5'd0));
        wb_en     = rdWrite && !mem_read && rd_ok;
        load_done = !is_store && (((state == MEM_REQ) && m_gnt && m_rvalid) ||
                                  ((state == MEM_WAIT) && m_rvalid));
        tmo_hit   = (tmo_cnt == TMO_LAST);
        rf_we     = wb_en;
        rf_wd     = result_out;
        // Returning load data owns the write port over a plain writeback.
        if (load_done && rdWrite && rd_ok) begin
            rf_we = 1'b1;
            rf_wd = m_rdata;
        end
        rd_a = (wb_en && (rdOut == rs1Out)) ? result_out : regfile[rs1Out];
        rd_b = (wb_en && (rdOut == rs2Out)) ? result_out : regfile[rs2Out];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= '0;
            end
        end else if (rf_we) begin
            regfile[rdOut] <= rf_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            is_store   <= 1'b0;
            AmuxIn     <= '0;
            BmuxIn     <= '0;
            data_Ready <= 1'b0;
            mem_ack    <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (mem_write || mem_read) begin
                        state    <= MEM_REQ;
                        is_store <= mem_write;
                        m_req    <= 1'b1;
                        m_we     <= mem_write;
                        m_addr   <= mem_address;
                        m_wdata  <= mem_write ? result_out : 32'd0;
                    end else if (reg_select) begin
                        state <= REG_RSP;
                    end
                end
                REG_RSP: begin
                    AmuxIn     <= rd_a;
                    BmuxIn     <= rd_b;
                    data_Ready <= 1'b1;
                    state      <= DONE;
                end
                MEM_REQ, MEM_WAIT: begin
                    if ((state == MEM_REQ) && m_gnt) begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                    end
                    if (load_done) begin
                        AmuxIn  <= m_rdata;
                        mem_ack <= 1'b1;
                        state   <= DONE;
                    end else if ((state == MEM_REQ) && m_gnt) begin
                        if (is_store) begin
                            mem_ack <= 1'b1;
                            state   <= DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                            state   <= MEM_WAIT;
                        end
                    end else if (tmo_hit) begin
                        // Abort so the PE never hangs on a dead memory port.
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        bus_err <= 1'b1;
                        AmuxIn  <= '0;
                        mem_ack <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE: begin
                    if (!reg_select && !mem_read && !mem_write) begin
                        data_Ready <= 1'b0;
                        mem_ack    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_bus_responder.sv
// Scoreboarded bench for pe_bus_responder with MEM_TIMEOUT=4, ZERO_REG=1.
module tb_pe_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_select, rdWrite, mem_read, mem_write;
    logic [4:0]  rs1Out, rs2Out, rdOut;
    logic [31:0] result_out, mem_address;
    logic [31:0] AmuxIn, BmuxIn;
    logic        data_Ready, mem_ack;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic        bus_err;

    always #5 clk = ~clk;

    pe_bus_responder #(.MEM_TIMEOUT(4), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .reg_select(reg_select), .rs1Out(rs1Out), .rs2Out(rs2Out),
        .rdOut(rdOut), .rdWrite(rdWrite), .result_out(result_out),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .AmuxIn(AmuxIn), .BmuxIn(BmuxIn), .data_Ready(data_Ready), .mem_ack(mem_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        chk_a;
        logic        chk_b;
        logic        mem;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_rf [32];
    logic        exp_err;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) model_rf[r] = v;
    endtask

    task automatic push_rd(input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        e.a = model_rf[r1]; e.b = model_rf[r2];
        e.chk_a = 1'b1; e.chk_b = 1'b1; e.mem = 1'b0; e.err = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic push_mem(input logic chk_a, input logic [31:0] a);
        exp_t e;
        e.a = a; e.b = '0;
        e.chk_a = chk_a; e.chk_b = 1'b0; e.mem = 1'b1; e.err = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (data_Ready || mem_ack) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_resp_seen"}, 32'(seen), 32'd1);
        check({tag, "_sb_has_entry"}, 32'(exp_q.size() > 0), 32'd1);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_mem_ack"}, 32'(mem_ack), 32'(e.mem));
            check({tag, "_data_Ready"}, 32'(data_Ready), 32'(!e.mem));
            if (e.chk_a) check({tag, "_AmuxIn"}, AmuxIn, e.a);
            if (e.chk_b) check({tag, "_BmuxIn"}, BmuxIn, e.b);
            check({tag, "_bus_err"}, 32'(bus_err), 32'(e.err));
        end
    endtask

    task automatic finish_hs(input string tag);
        tick();
        check({tag, "_ack_held"}, 32'(data_Ready | mem_ack), 32'd1);
        reg_select = 1'b0; mem_read = 1'b0; mem_write = 1'b0; rdWrite = 1'b0;
        tick();
        check({tag, "_drop_data_Ready"}, 32'(data_Ready), 32'd0);
        check({tag, "_drop_mem_ack"}, 32'(mem_ack), 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at 500us, expected $finish earlier");
        $fatal(1, "bench stopped by watchdog");
    end

    initial begin
        reset = 1'b0;
        reg_select = 1'b0; rdWrite = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        rs1Out = '0; rs2Out = '0; rdOut = '0; result_out = '0; mem_address = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        exp_err = 1'b0;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        repeat (3) tick();
        check("rst_AmuxIn", AmuxIn, 32'd0);
        check("rst_BmuxIn", BmuxIn, 32'd0);
        check("rst_data_Ready", 32'(data_Ready), 32'd0);
        check("rst_mem_ack", 32'(mem_ack), 32'd0);
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        reset = 1'b1;
        tick();

        // Writeback then operand read, with exact two-edge latency.
        rdWrite = 1'b1; rdOut = 5'd5; result_out = 32'h1234_5678;
        model_wr(5'd5, 32'h1234_5678);
        tick();
        rdWrite = 1'b0;
        reg_select = 1'b1; rs1Out = 5'd5; rs2Out = 5'd0;
        push_rd(5'd5, 5'd0);
        tick();
        check("rd1_latency_edge_n", 32'(data_Ready), 32'd0);
        tick();
        check("rd1_latency_edge_n1", 32'(data_Ready), 32'd1);
        wait_resp("rd1");
        finish_hs("rd1");

        // Writeback raised together with reg_select.
        rdWrite = 1'b1; rdOut = 5'd7; result_out = 32'hA5A5_A5A5;
        model_wr(5'd7, 32'hA5A5_A5A5);
        reg_select = 1'b1; rs1Out = 5'd7; rs2Out = 5'd5;
        push_rd(5'd7, 5'd5);
        wait_resp("byp1");
        finish_hs("byp1");

        // Writeback landing on the very edge the operands are captured.
        reg_select = 1'b1; rs1Out = 5'd5; rs2Out = 5'd7;
        tick();
        rdWrite = 1'b1; rdOut = 5'd7; result_out = 32'h5A5A_0001;
        model_wr(5'd7, 32'h5A5A_0001);
        push_rd(5'd5, 5'd7);
        tick();
        rdWrite = 1'b0;
        wait_resp("byp2");
        finish_hs("byp2");

        // Store with grant withheld for three cycles.
        mem_write = 1'b1; mem_address = 32'h100; result_out = 32'hCAFE_F00D;
        push_mem(1'b0, 32'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            check("st_m_req", 32'(m_req), 32'd1);
            check("st_m_we", 32'(m_we), 32'd1);
            check("st_m_addr", m_addr, 32'h100);
            check("st_m_wdata", m_wdata, 32'hCAFE_F00D);
            check("st_mem_ack_early", 32'(mem_ack), 32'd0);
            if (c == 0) result_out = 32'h0;
            tick();
        end
        m_gnt = 1'b1;
        check("st_m_req_at_gnt", 32'(m_req), 32'd1);
        tick();
        m_gnt = 1'b0;
        wait_resp("st");
        check("st_m_req_after_gnt", 32'(m_req), 32'd0);
        finish_hs("st");

        // Load with writeback: grant, then rvalid two cycles later.
        mem_read = 1'b1; rdWrite = 1'b1; rdOut = 5'd9; mem_address = 32'h200;
        push_mem(1'b1, 32'h0000_BEEF);
        model_wr(5'd9, 32'h0000_BEEF);
        tick();
        check("ld_m_req", 32'(m_req), 32'd1);
        check("ld_m_we", 32'(m_we), 32'd0);
        check("ld_m_addr", m_addr, 32'h200);
        m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        check("ld_wait_m_req", 32'(m_req), 32'd0);
        check("ld_wait_mem_ack", 32'(mem_ack), 32'd0);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h0000_BEEF;
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        wait_resp("ld");
        finish_hs("ld");
        reg_select = 1'b1; rs1Out = 5'd9; rs2Out = 5'd5;
        push_rd(5'd9, 5'd5);
        wait_resp("rd9");
        finish_hs("rd9");

        // Load into x0, stray rvalid before grant, then grant+rvalid together.
        mem_read = 1'b1; rdWrite = 1'b1; rdOut = 5'd0; mem_address = 32'h300;
        push_mem(1'b1, 32'hDEAD_0000);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
        tick();
        check("ld0_stray_rv_m_req", 32'(m_req), 32'd1);
        check("ld0_stray_rv_mem_ack", 32'(mem_ack), 32'd0);
        m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEAD_0000;
        tick();
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        check("ld0_m_req_drop", 32'(m_req), 32'd0);
        wait_resp("ld0");
        finish_hs("ld0");
        reg_select = 1'b1; rs1Out = 5'd0; rs2Out = 5'd9;
        push_rd(5'd0, 5'd9);
        wait_resp("rd0");
        finish_hs("rd0");

        // Store and operand read raised together: store wins.
        mem_write = 1'b1; reg_select = 1'b1; mem_address = 32'h400; result_out = 32'h1111_2222;
        rs1Out = 5'd9; rs2Out = 5'd7;
        push_mem(1'b0, 32'd0);
        push_rd(5'd9, 5'd7);
        tick();
        check("pri_m_req", 32'(m_req), 32'd1);
        check("pri_m_we", 32'(m_we), 32'd1);
        check("pri_data_Ready", 32'(data_Ready), 32'd0);
        m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        wait_resp("pri_st");
        finish_hs("pri_st");
        reg_select = 1'b1;
        wait_resp("pri_rd");
        finish_hs("pri_rd");

        // Load with grant tied low: timeout after four request cycles.
        mem_read = 1'b1; rdWrite = 1'b1; rdOut = 5'd9; mem_address = 32'h500;
        exp_err = 1'b1;
        push_mem(1'b1, 32'd0);
        tick();
        n_req = 0;
        while (m_req && n_req < 10) begin
            n_req++;
            tick();
        end
        check("tmo_req_cycles", 32'(n_req), 32'd4);
        wait_resp("tmo");
        finish_hs("tmo");
        reg_select = 1'b1; rs1Out = 5'd9; rs2Out = 5'd0;
        push_rd(5'd9, 5'd0);
        wait_resp("tmo_sticky");
        finish_hs("tmo_sticky");

        // Reset while a load is in MEM_WAIT, then a late rvalid.
        reg_select = 1'b1; rs1Out = 5'd9; rs2Out = 5'd0;
        push_rd(5'd9, 5'd0);
        wait_resp("pre_rst");
        finish_hs("pre_rst");
        mem_read = 1'b1; mem_address = 32'h600;
        tick();
        m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_wait_m_req", 32'(m_req), 32'd0);
        check("rst_wait_mem_ack", 32'(mem_ack), 32'd0);
        check("rst_wait_AmuxIn", AmuxIn, 32'd0);
        check("rst_wait_bus_err", 32'(bus_err), 32'd0);
        exp_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        mem_read = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h0000_0777;
        tick();
        tick();
        reset = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        check("rst_late_rv_mem_ack", 32'(mem_ack), 32'd0);
        check("rst_late_rv_AmuxIn", AmuxIn, 32'd0);
        check("rst_late_rv_m_req", 32'(m_req), 32'd0);

        // Reset while a store request is pending.
        mem_write = 1'b1; mem_address = 32'h700; result_out = 32'h7777_0000;
        tick();
        check("rst_req_m_req_pre", 32'(m_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_req_m_req", 32'(m_req), 32'd0);
        mem_write = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Register file must have been cleared by reset.
        reg_select = 1'b1; rs1Out = 5'd5; rs2Out = 5'd9;
        push_rd(5'd5, 5'd9);
        wait_resp("rd_after_rst");
        finish_hs("rd_after_rst");

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
